// File: rtl/wave_capture_pkg.sv
// Shared constants, FSM state encodings and the signed-to-offset-binary conversion
// used by the wave capture block.
package wave_capture_pkg;

    localparam int DEFAULT_AUTO_TIMEOUT = 1024;

    // Widest sample the conversion helper handles; SAMPLE_W must not exceed it.
    localparam int CONV_W = 32;

    typedef logic [1:0] state_t;
    localparam state_t ST_ARMED  = 2'd0;
    localparam state_t ST_ACTIVE = 2'd1;
    localparam state_t ST_WAIT   = 2'd2;

    // Keep the top out_w bits of a sample_w-bit two's complement value and flip the MSB.
    function automatic logic [CONV_W-1:0] to_offset_bin(input logic [CONV_W-1:0] s,
                                                        input int sample_w,
                                                        input int out_w);
        logic [CONV_W-1:0] r;
        r = s >> (sample_w - out_w);
        r = r & ((CONV_W'(1) << out_w) - CONV_W'(1));
        r = r ^ (CONV_W'(1) << (out_w - 1));
        return r;
    endfunction

endpackage

// File: rtl/wave_capture_mc_trigger.sv
// Zero-crossing detector: selects the watched channel, remembers its previous sample and
// raises a one-cycle trig pulse on the chosen crossing direction.
module wave_trigger
    import wave_capture_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int SAMPLE_W = 16,
    parameter int SEL_W    = 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         new_sample_ready,
    input  logic [CHANNELS*SAMPLE_W-1:0] new_sample_in,
    input  logic [SEL_W-1:0]             trig_channel,
    input  logic                         trig_falling,
    input  logic                         enable,
    output logic                         trig
);

    localparam logic signed [SAMPLE_W-1:0] ZERO = '0;

    logic signed [SAMPLE_W-1:0] cur;
    logic signed [SAMPLE_W-1:0] prev_q;
    logic                       rising;
    logic                       falling;

    always_comb begin
        cur = new_sample_in[SAMPLE_W-1:0];
        for (int c = 0; c < CHANNELS; c++) begin
            if (trig_channel == SEL_W'(c)) begin
                cur = new_sample_in[c*SAMPLE_W +: SAMPLE_W];
            end
        end
    end

    // Tracks whichever channel is selected at each strobe, in every capture state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= '0;
        end else if (new_sample_ready) begin
            prev_q <= cur;
        end
    end

    always_comb begin
        rising  = (prev_q < ZERO) && (cur >= ZERO);
        falling = (prev_q >= ZERO) && (cur < ZERO);
        trig    = new_sample_ready && enable && (trig_falling ? falling : rising);
    end

endmodule

// File: rtl/wave_capture_mc.sv
// Multi-channel triggered waveform capture into a ping-pong sample RAM.
// Optional timeout-forced trigger enabled by defining WAVE_CAPTURE_AUTOTRIG_EN.
module wave_capture_mc
    import wave_capture_pkg::*;
#(
    parameter int CHANNELS     = 2,
    parameter int SAMPLE_W     = 16,
    parameter int OUT_W        = 8,
    parameter int ADDR_W       = 8,
    parameter int AUTO_TIMEOUT = DEFAULT_AUTO_TIMEOUT
) (
    input  logic                                           clk,
    input  logic                                           reset_n,
    input  logic                                           new_sample_ready,
    input  logic [CHANNELS*SAMPLE_W-1:0]                   new_sample_in,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] trig_channel,
    input  logic                                           trig_falling,
    input  logic                                           wave_display_idle,
    output logic [ADDR_W:0]                                write_address,
    output logic                                           write_enable,
    output logic [CHANNELS*OUT_W-1:0]                      write_sample,
    output logic                                           read_index,
    output logic                                           auto_triggered
);

    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    state_t                    state_q;
    state_t                    state_d;
    logic [ADDR_W-1:0]         cnt_q;
    logic                      read_index_q;
    logic                      write_enable_q;
    logic [ADDR_W:0]           write_address_q;
    logic [CHANNELS*OUT_W-1:0] write_sample_q;
    logic                      auto_q;

    logic                      trig;
    logic                      auto_fire;
    logic                      start;
    logic                      do_write;
    logic                      flip;
    logic [CHANNELS*OUT_W-1:0] conv;

    wave_trigger #(
        .CHANNELS (CHANNELS),
        .SAMPLE_W (SAMPLE_W),
        .SEL_W    (SEL_W)
    ) u_trigger (
        .clk              (clk),
        .reset_n          (reset_n),
        .new_sample_ready (new_sample_ready),
        .new_sample_in    (new_sample_in),
        .trig_channel     (trig_channel),
        .trig_falling     (trig_falling),
        .enable           (state_q == ST_ARMED),
        .trig             (trig)
    );

`ifdef WAVE_CAPTURE_AUTOTRIG_EN
    localparam int TMO_W = $clog2(AUTO_TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_q;

    // Leaving ARMED clears the count, so every new ARMED visit starts from zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= '0;
        end else if (state_q != ST_ARMED) begin
            tmo_q <= '0;
        end else if (new_sample_ready) begin
            tmo_q <= tmo_q + TMO_W'(1);
        end
    end

    assign auto_fire = new_sample_ready && (state_q == ST_ARMED) &&
                       (tmo_q == TMO_W'(AUTO_TIMEOUT - 1));
`else
    assign auto_fire = 1'b0;
`endif

    always_comb begin
        conv = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            conv[c*OUT_W +: OUT_W] =
                OUT_W'(to_offset_bin(CONV_W'(new_sample_in[c*SAMPLE_W +: SAMPLE_W]),
                                     SAMPLE_W, OUT_W));
        end
    end

    always_comb begin
        state_d = state_q;
        start   = 1'b0;
        flip    = 1'b0;
        unique case (state_q)
            ST_ARMED: begin
                if (trig || auto_fire) begin
                    start   = 1'b1;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: ;
            ST_WAIT: begin
                if (wave_display_idle) begin
                    flip    = 1'b1;
                    state_d = ST_ARMED;
                end
            end
            default: state_d = ST_ARMED;
        endcase
        do_write = start || ((state_q == ST_ACTIVE) && new_sample_ready);
        if (do_write && (cnt_q == '1)) begin
            state_d = ST_WAIT;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_ARMED;
            cnt_q           <= '0;
            read_index_q    <= 1'b0;
            write_enable_q  <= 1'b0;
            write_address_q <= {1'b1, {ADDR_W{1'b0}}};
            write_sample_q  <= '0;
            auto_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            write_enable_q <= do_write;
            if (do_write) begin
                write_address_q <= {~read_index_q, cnt_q};
                write_sample_q  <= conv;
                cnt_q           <= cnt_q + ADDR_W'(1);
            end
            if (start) begin
                auto_q <= auto_fire && !trig;
            end
            if (flip) begin
                read_index_q <= ~read_index_q;
            end
        end
    end

    assign write_address  = write_address_q;
    assign write_enable   = write_enable_q;
    assign write_sample   = write_sample_q;
    assign read_index     = read_index_q;
    assign auto_triggered = auto_q;

endmodule

// File: tb/tb_wave_capture_mc.sv
// Directed bench for wave_capture_mc with a behavioural capture model checked every cycle.
module tb_wave_capture_mc;

    localparam int TMO = 16;
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
    localparam bit AUTO_EN = 1'b1;
`else
    localparam bit AUTO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        new_sample_ready = 1'b0;
    logic [31:0] new_sample_in = '0;
    logic [0:0]  trig_channel = 1'b0;
    logic        trig_falling = 1'b0;
    logic        wave_display_idle = 1'b0;
    logic [8:0]  write_address;
    logic        write_enable;
    logic [15:0] write_sample;
    logic        read_index;
    logic        auto_triggered;

    int total = 0;
    int bad = 0;
    int hits [512];

    // Model state: mode 0 = waiting for trigger, 1 = capturing, 2 = buffer full.
    int m_mode, m_ri, m_cnt, m_prev, m_tmo;
    bit m_auto, e_we;
    int e_addr, e_samp;

    wave_capture_mc #(
        .CHANNELS     (2),
        .SAMPLE_W     (16),
        .OUT_W        (8),
        .ADDR_W       (8),
        .AUTO_TIMEOUT (TMO)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .new_sample_ready  (new_sample_ready),
        .new_sample_in     (new_sample_in),
        .trig_channel      (trig_channel),
        .trig_falling      (trig_falling),
        .wave_display_idle (wave_display_idle),
        .write_address     (write_address),
        .write_enable      (write_enable),
        .write_sample      (write_sample),
        .read_index        (read_index),
        .auto_triggered    (auto_triggered)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sval(input int u);
        return (u >= 32768) ? u - 65536 : u;
    endfunction

    // Offset binary: add half range, keep the top byte.
    function automatic int exp_conv(input int u);
        return ((u + 32768) % 65536) / 256;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_ri = 0; m_cnt = 0; m_prev = 0; m_tmo = 0; m_auto = 1'b0;
        e_we = 1'b0; e_addr = 256; e_samp = 0;
    endtask

    task automatic model_step();
        int  mode0, d0, d1, cur;
        bit  crossing;
        mode0 = m_mode;
        e_we  = 1'b0;
        if (mode0 == 2 && wave_display_idle) begin
            m_ri   = 1 - m_ri;
            m_mode = 0;
            m_tmo  = 0;
        end
        if (new_sample_ready) begin
            d0  = int'(new_sample_in[15:0]);
            d1  = int'(new_sample_in[31:16]);
            cur = sval(trig_channel[0] ? d1 : d0);
            if (mode0 == 0) begin
                crossing = trig_falling ? (m_prev >= 0 && cur < 0) : (m_prev < 0 && cur >= 0);
                m_tmo++;
                if (crossing || (AUTO_EN && m_tmo == TMO)) begin
                    m_mode = 1;
                    m_cnt  = 0;
                    m_auto = !crossing;
                end
            end
            if (m_mode == 1) begin
                e_we   = 1'b1;
                e_addr = (1 - m_ri) * 256 + m_cnt;
                e_samp = exp_conv(d1) * 256 + exp_conv(d0);
                m_cnt++;
                if (m_cnt == 256) begin
                    m_mode = 2;
                    m_cnt  = 0;
                end
            end
            m_prev = cur;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                cmp("we", int'(write_enable), int'(e_we));
                cmp("addr", int'(write_address), e_addr);
                cmp("sample", int'(write_sample), e_samp);
                cmp("read_index", int'(read_index), m_ri);
                cmp("auto", int'(auto_triggered), int'(m_auto));
                if (write_enable) hits[write_address]++;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input bit s, input logic [15:0] d0, input logic [15:0] d1,
                         input bit idle);
        @(posedge clk);
        #1;
        new_sample_ready  = s;
        new_sample_in     = {d1, d0};
        wave_display_idle = idle;
    endtask

    task automatic quiet();
        drive(1'b0, 16'h0, 16'h0, 1'b0);
    endtask

    task automatic clear_hits();
        for (int a = 0; a < 512; a++) hits[a] = 0;
    endtask

    task automatic check_hits(input string name, input int base);
        int once, sum;
        once = 0;
        sum  = 0;
        for (int a = 0; a < 512; a++) begin
            sum += hits[a];
            if (a >= base && a < base + 256 && hits[a] == 1) once++;
        end
        cmp({name, "_once"}, once, 256);
        cmp({name, "_total"}, sum, 256);
        clear_hits();
    endtask

    initial begin
        clear_hits();
        repeat (3) @(posedge clk);
        #1;
        cmp("rst_we", int'(write_enable), 0);
        cmp("rst_addr", int'(write_address), 9'h100);
        cmp("rst_sample", int'(write_sample), 0);
        cmp("rst_ri", int'(read_index), 0);
        cmp("rst_auto", int'(auto_triggered), 0);
        reset_n = 1'b1;
        quiet();
        quiet();

        // Negative first sample after prev=0 is not a rising crossing.
        drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
        quiet();
        cmp("no_trig_we", int'(write_enable), 0);
        drive(1'b1, 16'h0001, 16'h0001, 1'b0);
        quiet();
        cmp("trig_we", int'(write_enable), 1);
        cmp("trig_addr", int'(write_address), 9'h100);
        cmp("trig_sample", int'(write_sample), 16'h8080);
        cmp("trig_auto", int'(auto_triggered), 0);

        drive(1'b1, 16'h8000, 16'h7FFF, 1'b0);
        quiet();
        cmp("ext_addr", int'(write_address), 9'h101);
        cmp("ext_sample", int'(write_sample), 16'hFF00);
        for (int i = 2; i < 256; i++) begin
            if (i == 100) begin trig_channel = 1'b1; trig_falling = 1'b1; end
            if (i == 150) begin trig_channel = 1'b0; trig_falling = 1'b0; end
            drive(1'b1, 16'(i * 251), 16'(i * 4099 + 7), 1'b0);
        end
        quiet();
        cmp("last_addr", int'(write_address), 9'h1FF);
        cmp("last_we", int'(write_enable), 1);
        drive(1'b1, 16'h1000, 16'h1000, 1'b0);
        quiet();
        cmp("wait_no_write", int'(write_enable), 0);
        check_hits("cap1", 256);

        drive(1'b0, 16'h0, 16'h0, 1'b1);
        quiet();
        cmp("flip_ri", int'(read_index), 1);

        // Falling edge on channel 1 while channel 0 toggles sign.
        trig_channel = 1'b1;
        trig_falling = 1'b1;
        drive(1'b1, 16'hFFFF, 16'h0010, 1'b0);
        drive(1'b1, 16'h0001, 16'h0010, 1'b0);
        drive(1'b1, 16'hFFFF, 16'h0010, 1'b0);
        quiet();
        cmp("ch1_no_trig", int'(write_enable), 0);
        drive(1'b1, 16'h1234, 16'hFFF0, 1'b0);
        quiet();
        cmp("ch1_we", int'(write_enable), 1);
        cmp("ch1_addr", int'(write_address), 9'h000);
        cmp("ch1_sample", int'(write_sample), 16'h7F92);
        for (int i = 1; i < 256; i++) begin
            drive(1'b1, 16'(i * 977 + 3), 16'(65535 - i * 131), 1'b0);
        end
        quiet();
        cmp("cap2_last", int'(write_address), 9'h0FF);
        drive(1'b1, 16'h1000, 16'h1000, 1'b0);
        drive(1'b0, 16'h0, 16'h0, 1'b1);
        quiet();
        cmp("flip_back_ri", int'(read_index), 0);
        check_hits("cap2", 0);

        // Abort a capture at counter 100 with an asynchronous reset.
        trig_channel = 1'b0;
        trig_falling = 1'b0;
        drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 16'(i + 1), 16'(i * 300), 1'b0);
        end
        quiet();
        cmp("pre_abort_addr", int'(write_address), 9'h163);
        #3;
        reset_n = 1'b0;
        #1;
        cmp("abort_we", int'(write_enable), 0);
        cmp("abort_addr", int'(write_address), 9'h100);
        cmp("abort_sample", int'(write_sample), 0);
        cmp("abort_ri", int'(read_index), 0);
        clear_hits();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        quiet();
        cmp("post_rst_addr", int'(write_address), 9'h100);
        cmp("post_rst_we", int'(write_enable), 0);
        drive(1'b1, 16'hFFFF, 16'hFFFF, 1'b0);
        drive(1'b1, 16'h0001, 16'h0001, 1'b0);
        quiet();
        cmp("rearm_we", int'(write_enable), 1);
        cmp("rearm_addr", int'(write_address), 9'h100);
        for (int i = 1; i < 256; i++) begin
            drive(1'b1, 16'(i * 7), 16'(i * 13), 1'b0);
        end
        drive(1'b1, 16'h1000, 16'h1000, 1'b0);
        drive(1'b0, 16'h0, 16'h0, 1'b1);
        quiet();
        cmp("cap3_ri", int'(read_index), 1);
        check_hits("cap3", 256);

        // Constant positive input never crosses zero.
        for (int k = 0; k < TMO; k++) drive(1'b1, 16'h1000, 16'h1000, 1'b0);
        quiet();
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
        cmp("tmo_we", int'(write_enable), 1);
        cmp("tmo_addr", int'(write_address), 9'h000);
        cmp("tmo_sample", int'(write_sample), 16'h9090);
        cmp("tmo_auto", int'(auto_triggered), 1);
`else
        cmp("tmo_we", int'(write_enable), 0);
`endif
        for (int k = 0; k < 4; k++) drive(1'b1, 16'h1000, 16'h1000, 1'b0);
        quiet();
        quiet();
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
        cmp("tmo_follow_addr", int'(write_address), 9'h004);
        cmp("tmo_auto_hold", int'(auto_triggered), 1);
`else
        begin
            int sum;
            sum = 0;
            for (int a = 0; a < 512; a++) sum += hits[a];
            cmp("tmo_no_writes", sum, 0);
        end
`endif
        quiet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wave_capture_mc.md
# wave_capture_mc

Multi-channel triggered waveform capture for the wave display path. It watches a selectable channel of the incoming signed audio stream for a zero crossing. On a crossing it writes a full buffer of down-converted samples for all channels into one half of a ping-pong sample RAM. When the display reports idle, it flips the ping-pong index. It sits between the codec/sample source and the wave display RAM, and is the parametrised successor to the single-channel, fixed-width capture block.

## Interface
Parameters:
- CHANNELS, 2, number of parallel audio channels (≥1)
- SAMPLE_W, 16, signed input sample width per channel
- OUT_W, 8, stored sample width per channel (OUT_W ≤ SAMPLE_W)
- ADDR_W, 8, log2 of samples per buffer half
- AUTO_TIMEOUT, 1024, samples in ARMED before forced trigger (used only with WAVE_CAPTURE_AUTOTRIG_EN)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- new_sample_ready  in  1  single-cycle strobe; new_sample_in valid this cycle
- new_sample_in  in  CHANNELS*SAMPLE_W  channel c at bits [c*SAMPLE_W +: SAMPLE_W], two's complement
- trig_channel  in  max(1,$clog2(CHANNELS))  channel watched for trigger
- trig_falling  in  1  0 = rising crossing, 1 = falling crossing
- wave_display_idle  in  1  display finished with the current read half
- write_address  out  ADDR_W+1  {~read_index, sample counter}
- write_enable  out  1  one-cycle RAM write strobe
- write_sample  out  CHANNELS*OUT_W  packed offset-binary samples, same channel order as input
- read_index  out  1  half the display reads
- auto_triggered  out  1  current/last capture was forced by timeout

## Operation
- States: ARMED, ACTIVE, WAIT. Reset state is ARMED.
- Previous-sample register for the trigger channel updates on every new_sample_ready, in every state. Reset value is 0.
- Trigger condition, evaluated on a strobe in ARMED:
  - Rising: prev < 0 and cur ≥ 0.
  - Falling: prev ≥ 0 and cur < 0.
  - Channel select and edge are sampled at that strobe only. Changes during ACTIVE or WAIT do not affect the capture in progress.
- ARMED → ACTIVE on trigger. The triggering sample is written at counter 0.
- ACTIVE: every strobe writes one word and increments the counter.
  - After the write at counter 2^ADDR_W−1, the counter wraps to 0 and the state goes to WAIT.
- WAIT: strobes are not written. wave_display_idle=1 toggles read_index and goes to ARMED.
- wave_display_idle is ignored in ARMED and ACTIVE.
- Conversion per channel: take the top OUT_W bits of the sample and invert the MSB. This maps signed to offset binary: 0x8000 → 0x00, 0x0000 → 0x80, 0x7FFF → 0xFF.

## Timing
- Reset values: write_enable=0, write_address=0x100 (ADDR_W=8; read_index=0, counter=0), write_sample=0, read_index=0, auto_triggered=0, state ARMED.
- Write latency: the triggering or ACTIVE strobe in cycle N produces write_enable=1 in cycle N+1. write_address and write_sample are registered and valid in the same cycle.
- Back-to-back strobes are supported; each produces one write one cycle later.
- write_address high bit is the complement of read_index at the time of the write. Writes never target the half being read.
- WAIT exit: wave_display_idle high in cycle N → read_index toggled and state ARMED in cycle N+1.
- A strobe in that same cycle N updates the previous-sample register but is not tested for trigger.
- Asserting reset_n low mid-capture aborts immediately. All outputs take reset values asynchronously, and the partial buffer is abandoned.

## Configuration
- Macro: WAVE_CAPTURE_AUTOTRIG_EN.
- Defined:
  - A timeout counter counts strobes while in ARMED and clears on entry to ARMED.
  - The strobe that brings the count to AUTO_TIMEOUT without a real trigger forces ARMED → ACTIVE. That sample is written at address 0.
  - auto_triggered=1 from that write until the next ARMED → ACTIVE transition.
  - A real trigger on the same strobe takes priority, and auto_triggered stays 0.
- Undefined: no timeout counter, ARMED waits indefinitely, and auto_triggered is tied to 0.

## Structure
- Package wave_capture_pkg:
  - state enum (ARMED, ACTIVE, WAIT);
  - offset-binary conversion function parametrised by SAMPLE_W/OUT_W;
  - constant for the default AUTO_TIMEOUT.
- Sub-module wave_trigger: channel mux, previous-sample register, and edge compare. Its output is a one-cycle trig pulse.
- The FSM, counter and output registers stay in the top.

## Test plan
- Reset, then prev=0 and strobe cur=0xFFFF on channel 0 (rising) → no trigger. Next strobe 0x0001 after 0xFFFF → write_enable one cycle later, address 0x100, sample 0x80.
- Full capture: 256 strobes after trigger → addresses 0x100..0x1FF, each written exactly once. The 257th strobe produces no write, and the state is WAIT.
- WAIT with wave_display_idle=1 for one cycle → read_index=1 next cycle. The next capture writes 0x000..0x0FF.
- trig_falling=1, trig_channel=1, channel 1 goes 0x0010 → 0xFFF0 while channel 0 toggles sign → trigger only on channel 1. Packed write_sample shows channel 1 = 0x7F, channel 0 converted correctly.
- Assert reset_n low at counter 100 → outputs return to reset values without waiting for a clock. After release, ARMED with address 0x100.
- With WAVE_CAPTURE_AUTOTRIG_EN and AUTO_TIMEOUT=16, constant input 0x1000 → capture starts at the 16th strobe with auto_triggered=1. Without the macro, no write ever occurs.
